// File: rtl/switch_mcu_ex_ctrl_pkg.sv
// Shared types and constants for the execute-unit sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package switch_mcu_ex_ctrl_pkg;

    // Register-file port widths.
    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    // Shared cycle counter width; holds up to LAST_CYCLE+1 = 15.
    localparam int CNT_W = 4;

    // Default compute/writeback cycle. The legal range is 2..14.
    localparam int LAST_CYCLE_DEF = 4;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // One register-file port set: one read port and one write port.
    typedef struct packed {
        logic              ren;
        logic [REG_AW-1:0] raddr;
        logic              wen;
        logic [REG_AW-1:0] waddr;
        logic [REG_DW-1:0] wdata;
    } rf_port_t;

endpackage

// File: rtl/switch_mcu_ex_ctrl_if.sv
// Bundle between the decoder/execute units and the sequencer.
// Latency: none (wires only).
// Backpressure: out_inst_ready gates the decoder; units have none.
interface switch_mcu_ex_ctrl_if #(
    parameter int NUM_UNITS = 4
) ();
    import switch_mcu_ex_ctrl_pkg::*;

    // Decoder handshake.
    logic                          in_inst_valid;
    logic                          out_inst_ready;
    logic [NUM_UNITS-1:0]          in_unit_sel;
    logic                          in_flush;

    // Unit control.
    logic [NUM_UNITS-1:0]          out_unit_en;
    logic [CNT_W-1:0]              out_cycle_cnt;

    // Per-unit register-file requests, unit k at slice k.
    logic [NUM_UNITS-1:0]          in_unit_ren_1;
    logic [NUM_UNITS*REG_AW-1:0]   in_unit_raddr_1;
    logic [NUM_UNITS-1:0]          in_unit_wen;
    logic [NUM_UNITS*REG_AW-1:0]   in_unit_waddr;
    logic [NUM_UNITS*REG_DW-1:0]   in_unit_wdata;

    // Shared register-file port.
    logic                          out_rf_ren_1;
    logic [REG_AW-1:0]             out_rf_raddr_1;
    logic                          out_rf_wen;
    logic [REG_AW-1:0]             out_rf_waddr;
    logic [REG_DW-1:0]             out_rf_wdata;

    // Status back to fetch.
    logic                          out_retire;
    logic                          out_err;

    // Decoder and execute units drive requests.
    modport master (
        output in_inst_valid, in_unit_sel, in_flush,
        output in_unit_ren_1, in_unit_raddr_1, in_unit_wen, in_unit_waddr, in_unit_wdata,
        input  out_inst_ready, out_unit_en, out_cycle_cnt,
        input  out_rf_ren_1, out_rf_raddr_1, out_rf_wen, out_rf_waddr, out_rf_wdata,
        input  out_retire, out_err
    );

    // Sequencer side.
    modport slave (
        input  in_inst_valid, in_unit_sel, in_flush,
        input  in_unit_ren_1, in_unit_raddr_1, in_unit_wen, in_unit_waddr, in_unit_wdata,
        output out_inst_ready, out_unit_en, out_cycle_cnt,
        output out_rf_ren_1, out_rf_raddr_1, out_rf_wen, out_rf_waddr, out_rf_wdata,
        output out_retire, out_err
    );

endinterface

// File: rtl/switch_mcu_rf_port_mux.sv
// One-hot AND-OR mux of per-unit register-file port fields onto one port set.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs are all-zero whenever active is low.
module switch_mcu_rf_port_mux
    import switch_mcu_ex_ctrl_pkg::*;
#(
    parameter int NUM_UNITS = 4
) (
    input  logic [NUM_UNITS-1:0]        sel,
    input  logic                        active,
    input  logic [NUM_UNITS-1:0]        ren,
    input  logic [NUM_UNITS*REG_AW-1:0] raddr,
    input  logic [NUM_UNITS-1:0]        wen,
    input  logic [NUM_UNITS*REG_AW-1:0] waddr,
    input  logic [NUM_UNITS*REG_DW-1:0] wdata,
    output rf_port_t                    rf_out
);

    // OR together every unit's fields masked by (active & its select bit).
    always_comb begin
        rf_out = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            rf_out.ren   = rf_out.ren   | (active & sel[k] & ren[k]);
            rf_out.raddr = rf_out.raddr | (raddr[k*REG_AW +: REG_AW] & {REG_AW{active & sel[k]}});
            rf_out.wen   = rf_out.wen   | (active & sel[k] & wen[k]);
            rf_out.waddr = rf_out.waddr | (waddr[k*REG_AW +: REG_AW] & {REG_AW{active & sel[k]}});
            rf_out.wdata = rf_out.wdata | (wdata[k*REG_DW +: REG_DW] & {REG_DW{active & sel[k]}});
        end
    end

endmodule

// File: rtl/switch_mcu_ex_ctrl.sv
// Sequencer for multi-cycle execute units: counter, unit enable, RF port routing.
// Latency: accept at E0, RUN for LAST_CYCLE cycles, WB one cycle, IDLE again (LAST_CYCLE+2 per instruction).
// Backpressure: out_inst_ready only in IDLE and not while flushing; flush aborts at any time.
module switch_mcu_ex_ctrl
    import switch_mcu_ex_ctrl_pkg::*;
#(
    parameter int NUM_UNITS  = 4,
    parameter int LAST_CYCLE = LAST_CYCLE_DEF   // legal range 2..14
) (
    input  logic               in_clk,
    input  logic               in_rst,
    switch_mcu_ex_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_CYCLE);

    state_t               state_q, state_d;
    logic [NUM_UNITS-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic                 inst_ready;
    logic                 xfer;
    logic                 sel_legal;
    logic                 mux_act;
    logic [NUM_UNITS-1:0] unit_en;
    logic                 retire;
    rf_port_t             rf_mux;

    assign inst_ready = (state_q == ST_IDLE) && !bus.in_flush;
    assign xfer       = bus.in_inst_valid && inst_ready;
    assign sel_legal  = $onehot(bus.in_unit_sel);

    // State, counter, select latch and error pulse; reset drops everything at once.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state: flush wins, otherwise IDLE -> RUN -> WB -> IDLE with the counter tracking the cycle.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (bus.in_flush) begin
            state_d = ST_IDLE;
            sel_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        if (sel_legal) begin
                            state_d = ST_RUN;
                            sel_d   = bus.in_unit_sel;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            // Illegal select is dropped and reported the following cycle.
                            err_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_WB;
                        cnt_d   = LAST_CNT + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WB: begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs: enable only while running; WB keeps the port routed so the unit's write lands, and retires.
    always_comb begin
        unit_en = '0;
        retire  = 1'b0;
        mux_act = 1'b0;
        case (state_q)
            ST_RUN: begin
                unit_en = sel_q;
                mux_act = 1'b1;
            end
            ST_WB: begin
                retire  = !bus.in_flush;
                mux_act = 1'b1;
            end
            default: begin
                unit_en = '0;
            end
        endcase
    end

    switch_mcu_rf_port_mux #(
        .NUM_UNITS (NUM_UNITS)
    ) u_rf_port_mux (
        .sel    (sel_q),
        .active (mux_act),
        .ren    (bus.in_unit_ren_1),
        .raddr  (bus.in_unit_raddr_1),
        .wen    (bus.in_unit_wen),
        .waddr  (bus.in_unit_waddr),
        .wdata  (bus.in_unit_wdata),
        .rf_out (rf_mux)
    );

    assign bus.out_inst_ready = inst_ready;
    assign bus.out_unit_en    = unit_en;
    assign bus.out_cycle_cnt  = cnt_q;
    assign bus.out_retire     = retire;
    assign bus.out_err        = err_q;
    assign bus.out_rf_ren_1   = rf_mux.ren;
    assign bus.out_rf_raddr_1 = rf_mux.raddr;
    // A flush must never let a half-finished instruction commit its write.
    assign bus.out_rf_wen     = rf_mux.wen & ~bus.in_flush;
    assign bus.out_rf_waddr   = rf_mux.waddr;
    assign bus.out_rf_wdata   = rf_mux.wdata;

endmodule

// File: tb/tb_switch_mcu_ex_ctrl.sv
// Self-checking bench for switch_mcu_ex_ctrl with a transaction-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_switch_mcu_ex_ctrl;
    import switch_mcu_ex_ctrl_pkg::*;

    localparam int N  = 4;
    localparam int L  = 4;
    localparam int L2 = 2;

    logic in_clk;
    logic in_rst;
    int   n_checks;
    int   n_err;

    logic        u_ren  [N];
    logic [4:0]  u_raddr[N];
    logic        u_wen  [N];
    logic [4:0]  u_waddr[N];
    logic [31:0] u_wdata[N];

    // Reference model: cycles elapsed since acceptance (0 = free), chosen unit, pending error.
    int   m_phase;
    int   m_idx;
    logic m_err;

    switch_mcu_ex_ctrl_if #(.NUM_UNITS(N)) bus ();
    switch_mcu_ex_ctrl_if #(.NUM_UNITS(N)) bus2 ();

    switch_mcu_ex_ctrl #(.NUM_UNITS(N), .LAST_CYCLE(L)) dut (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .bus    (bus)
    );

    switch_mcu_ex_ctrl #(.NUM_UNITS(N), .LAST_CYCLE(L2)) dut2 (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .bus    (bus2)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    task automatic apply_units();
        for (int k = 0; k < N; k++) begin
            bus.in_unit_ren_1[k]          = u_ren[k];
            bus.in_unit_raddr_1[k*5 +: 5] = u_raddr[k];
            bus.in_unit_wen[k]            = u_wen[k];
            bus.in_unit_waddr[k*5 +: 5]   = u_waddr[k];
            bus.in_unit_wdata[k*32 +: 32] = u_wdata[k];
        end
    endtask

    // Advance the model using the inputs present at the rising edge.
    task automatic model_step();
        logic trans;
        logic legal;
        if (!in_rst) begin
            m_phase = 0;
            m_err   = 1'b0;
            return;
        end
        trans = (m_phase == 0) && bus.in_inst_valid && !bus.in_flush;
        legal = ($countones(bus.in_unit_sel) == 1);
        m_err = trans && !legal;
        if (bus.in_flush) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (trans && legal) begin
                m_phase = 1;
                for (int k = 0; k < N; k++)
                    if (bus.in_unit_sel[k]) m_idx = k;
            end
        end else if (m_phase == L + 1) begin
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        model_step();
        @(negedge in_clk);
    endtask

    task automatic test_reset();
        in_rst = 1'b0;
        tick();
        #1;
        n_checks++; if (bus.out_inst_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", bus.out_inst_ready); end
        n_checks++; if (bus.out_unit_en !== 4'b0) begin n_err++; $display("FAIL reset_en got=%b exp=0000", bus.out_unit_en); end
        n_checks++; if (bus.out_cycle_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", bus.out_cycle_cnt); end
        n_checks++; if (bus.out_retire !== 1'b0 || bus.out_err !== 1'b0) begin n_err++; $display("FAIL reset_pulses got retire=%b err=%b exp=0,0", bus.out_retire, bus.out_err); end
        n_checks++; if (bus2.out_inst_ready !== 1'b1 || bus2.out_cycle_cnt !== 4'd0) begin n_err++; $display("FAIL reset_dut2 got rdy=%b cnt=%0d exp=1,0", bus2.out_inst_ready, bus2.out_cycle_cnt); end
        in_rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        u_ren[0] = 1'b1; u_raddr[0] = 5'd3; u_wen[0] = 1'b1; u_waddr[0] = 5'd7; u_wdata[0] = 32'hDEADBEEF;
        apply_units();
        bus.in_inst_valid = 1'b1;
        bus.in_unit_sel   = 4'b0001;
        tick();
        bus.in_inst_valid = 1'b0;
        for (int c = 1; c <= L + 2; c++) begin
            #1;
            n_checks++; if (bus.out_cycle_cnt !== ((c <= L + 1) ? 4'(c) : 4'd0)) begin n_err++; $display("FAIL single_cnt c=%0d got=%0d", c, bus.out_cycle_cnt); end
            n_checks++; if (bus.out_unit_en !== ((c <= L) ? 4'b0001 : 4'b0000)) begin n_err++; $display("FAIL single_en c=%0d got=%b", c, bus.out_unit_en); end
            n_checks++; if (bus.out_retire !== (c == L + 1)) begin n_err++; $display("FAIL single_retire c=%0d got=%b", c, bus.out_retire); end
            n_checks++; if (bus.out_inst_ready !== (c == L + 2)) begin n_err++; $display("FAIL single_ready c=%0d got=%b", c, bus.out_inst_ready); end
            if (c == L + 1) begin
                n_checks++; if (bus.out_rf_wen !== 1'b1 || bus.out_rf_waddr !== 5'd7 || bus.out_rf_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_wb got wen=%b waddr=%0d wdata=%h exp 1,7,deadbeef", bus.out_rf_wen, bus.out_rf_waddr, bus.out_rf_wdata); end
                n_checks++; if (bus.out_rf_ren_1 !== 1'b1 || bus.out_rf_raddr_1 !== 5'd3) begin n_err++; $display("FAIL single_rd got ren=%b raddr=%0d exp 1,3", bus.out_rf_ren_1, bus.out_rf_raddr_1); end
            end
            if (c == L + 2) begin
                n_checks++; if (bus.out_rf_wen !== 1'b0 || bus.out_rf_wdata !== 32'd0) begin n_err++; $display("FAIL single_idle_port got wen=%b wdata=%h exp 0,0", bus.out_rf_wen, bus.out_rf_wdata); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < N; k++) begin
            u_ren[k] = 1'b1; u_raddr[k] = 5'(k + 1); u_wen[k] = 1'b1;
            u_waddr[k] = 5'(k + 16); u_wdata[k] = 32'hA5A5_0000 + 32'(k);
        end
        apply_units();
        bus.in_inst_valid = 1'b1;
        bus.in_unit_sel   = 4'b0010;
        tick();
        // Valid stays high with a new select; it must wait for the first to finish.
        bus.in_unit_sel = 4'b1000;
        for (int c = 1; c <= L + 1; c++) begin
            #1;
            n_checks++; if (bus.out_unit_en !== ((c <= L) ? 4'b0010 : 4'b0000)) begin n_err++; $display("FAIL b2b_en1 c=%0d got=%b", c, bus.out_unit_en); end
            n_checks++; if (bus.out_rf_waddr !== u_waddr[1] || bus.out_rf_wdata !== u_wdata[1] || bus.out_rf_raddr_1 !== u_raddr[1]) begin n_err++; $display("FAIL b2b_port1 c=%0d got waddr=%0d wdata=%h raddr=%0d", c, bus.out_rf_waddr, bus.out_rf_wdata, bus.out_rf_raddr_1); end
            tick();
        end
        #1;
        n_checks++; if (bus.out_inst_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b exp=1", bus.out_inst_ready); end
        tick();
        bus.in_inst_valid = 1'b0;
        for (int c = 1; c <= L + 1; c++) begin
            #1;
            n_checks++; if (bus.out_cycle_cnt !== 4'(c)) begin n_err++; $display("FAIL b2b_cnt2 c=%0d got=%0d", c, bus.out_cycle_cnt); end
            n_checks++; if (bus.out_unit_en !== ((c <= L) ? 4'b1000 : 4'b0000)) begin n_err++; $display("FAIL b2b_en2 c=%0d got=%b", c, bus.out_unit_en); end
            n_checks++; if (bus.out_rf_waddr !== u_waddr[3] || bus.out_rf_wdata !== u_wdata[3]) begin n_err++; $display("FAIL b2b_port2 c=%0d got waddr=%0d wdata=%h", c, bus.out_rf_waddr, bus.out_rf_wdata); end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [3:0] bad;
        for (int i = 0; i < 2; i++) begin
            bad = (i == 0) ? 4'b0000 : 4'b0110;
            bus.in_inst_valid = 1'b1;
            bus.in_unit_sel   = bad;
            tick();
            bus.in_inst_valid = 1'b0;
            #1;
            n_checks++; if (bus.out_err !== 1'b1) begin n_err++; $display("FAIL illegal_err sel=%b got=%b exp=1", bad, bus.out_err); end
            n_checks++; if (bus.out_unit_en !== 4'b0 || bus.out_cycle_cnt !== 4'd0 || bus.out_inst_ready !== 1'b1) begin n_err++; $display("FAIL illegal_state sel=%b got en=%b cnt=%0d rdy=%b", bad, bus.out_unit_en, bus.out_cycle_cnt, bus.out_inst_ready); end
            tick();
            #1;
            n_checks++; if (bus.out_err !== 1'b0 || bus.out_retire !== 1'b0) begin n_err++; $display("FAIL illegal_pulse sel=%b got err=%b retire=%b exp 0,0", bad, bus.out_err, bus.out_retire); end
        end
    endtask

    task automatic test_flush();
        bus.in_inst_valid = 1'b1;
        bus.in_unit_sel   = 4'b0100;
        tick();
        bus.in_inst_valid = 1'b0;
        tick();
        tick();
        #1;
        n_checks++; if (bus.out_cycle_cnt !== 4'd3) begin n_err++; $display("FAIL flush_pre_cnt got=%0d exp=3", bus.out_cycle_cnt); end
        bus.in_flush = 1'b1;
        #1;
        n_checks++; if (bus.out_rf_wen !== 1'b0) begin n_err++; $display("FAIL flush_run_wen got=%b exp=0", bus.out_rf_wen); end
        tick();
        bus.in_flush = 1'b0;
        #1;
        n_checks++; if (bus.out_cycle_cnt !== 4'd0 || bus.out_unit_en !== 4'b0 || bus.out_retire !== 1'b0 || bus.out_inst_ready !== 1'b1) begin n_err++; $display("FAIL flush_after got cnt=%0d en=%b retire=%b rdy=%b", bus.out_cycle_cnt, bus.out_unit_en, bus.out_retire, bus.out_inst_ready); end
        // Flush landing in the writeback cycle.
        bus.in_inst_valid = 1'b1;
        bus.in_unit_sel   = 4'b0001;
        tick();
        bus.in_inst_valid = 1'b0;
        repeat (L) tick();
        #1;
        n_checks++; if (bus.out_cycle_cnt !== 4'(L + 1) || bus.out_rf_wen !== 1'b1) begin n_err++; $display("FAIL flush_wb_pre got cnt=%0d wen=%b", bus.out_cycle_cnt, bus.out_rf_wen); end
        bus.in_flush = 1'b1;
        #1;
        n_checks++; if (bus.out_rf_wen !== 1'b0 || bus.out_retire !== 1'b0) begin n_err++; $display("FAIL flush_wb got wen=%b retire=%b exp 0,0", bus.out_rf_wen, bus.out_retire); end
        tick();
        bus.in_flush = 1'b0;
        #1;
        n_checks++; if (bus.out_cycle_cnt !== 4'd0 || bus.out_inst_ready !== 1'b1) begin n_err++; $display("FAIL flush_wb_after got cnt=%0d rdy=%b", bus.out_cycle_cnt, bus.out_inst_ready); end
    endtask

    task automatic test_async_reset();
        bus.in_inst_valid = 1'b1;
        bus.in_unit_sel   = 4'b0010;
        tick();
        bus.in_inst_valid = 1'b0;
        tick();
        #1;
        n_checks++; if (bus.out_cycle_cnt !== 4'd2) begin n_err++; $display("FAIL arst_pre_cnt got=%0d exp=2", bus.out_cycle_cnt); end
        #1;
        in_rst = 1'b0;
        #1;
        n_checks++; if (bus.out_cycle_cnt !== 4'd0 || bus.out_unit_en !== 4'b0 || bus.out_inst_ready !== 1'b1) begin n_err++; $display("FAIL arst_state got cnt=%0d en=%b rdy=%b", bus.out_cycle_cnt, bus.out_unit_en, bus.out_inst_ready); end
        n_checks++; if (bus.out_rf_wen !== 1'b0 || bus.out_rf_waddr !== 5'd0 || bus.out_retire !== 1'b0) begin n_err++; $display("FAIL arst_port got wen=%b waddr=%0d retire=%b", bus.out_rf_wen, bus.out_rf_waddr, bus.out_retire); end
        tick();
        in_rst = 1'b1;
        tick();
        bus.in_inst_valid = 1'b1;
        bus.in_unit_sel   = 4'b1000;
        tick();
        bus.in_inst_valid = 1'b0;
        #1;
        n_checks++; if (bus.out_cycle_cnt !== 4'd1 || bus.out_unit_en !== 4'b1000) begin n_err++; $display("FAIL arst_restart got cnt=%0d en=%b", bus.out_cycle_cnt, bus.out_unit_en); end
        repeat (L) tick();
        #1;
        n_checks++; if (bus.out_retire !== 1'b1 || bus.out_cycle_cnt !== 4'(L + 1)) begin n_err++; $display("FAIL arst_retire got retire=%b cnt=%0d", bus.out_retire, bus.out_cycle_cnt); end
        tick();
    endtask

    task automatic test_last2();
        bus2.in_inst_valid = 1'b1;
        bus2.in_unit_sel   = 4'b0100;
        tick();
        for (int c = 1; c <= L2 + 2; c++) begin
            #1;
            n_checks++; if (bus2.out_cycle_cnt !== ((c <= L2 + 1) ? 4'(c) : 4'd0)) begin n_err++; $display("FAIL last2_cnt c=%0d got=%0d", c, bus2.out_cycle_cnt); end
            n_checks++; if (bus2.out_retire !== (c == L2 + 1) || bus2.out_inst_ready !== (c == L2 + 2)) begin n_err++; $display("FAIL last2_ctl c=%0d got retire=%b rdy=%b", c, bus2.out_retire, bus2.out_inst_ready); end
            tick();
        end
        #1;
        n_checks++; if (bus2.out_cycle_cnt !== 4'd1 || bus2.out_unit_en !== 4'b0100) begin n_err++; $display("FAIL last2_next got cnt=%0d en=%b", bus2.out_cycle_cnt, bus2.out_unit_en); end
        bus2.in_inst_valid = 1'b0;
        repeat (L2 + 2) tick();
    endtask

    task automatic test_random();
        logic       e_rdy, e_ret, e_act, e_ren, e_wen;
        logic [3:0] e_en, e_cnt;
        logic [4:0] e_raddr, e_waddr;
        logic [31:0] e_wdata;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                u_ren[k]   = 1'($urandom_range(0, 1));
                u_raddr[k] = 5'($urandom);
                u_wen[k]   = 1'($urandom_range(0, 1));
                u_waddr[k] = 5'($urandom);
                u_wdata[k] = $urandom;
            end
            apply_units();
            bus.in_inst_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) < 6) bus.in_unit_sel = 4'(1 << $urandom_range(0, 3));
            else                          bus.in_unit_sel = 4'($urandom_range(0, 15));
            bus.in_flush = ($urandom_range(0, 19) == 0);
            #1;
            e_act   = (m_phase >= 1);
            e_rdy   = (m_phase == 0) && !bus.in_flush;
            e_en    = (m_phase >= 1 && m_phase <= L) ? 4'(1 << m_idx) : 4'b0;
            e_cnt   = 4'(m_phase);
            e_ret   = (m_phase == L + 1) && !bus.in_flush;
            e_ren   = e_act ? u_ren[m_idx] : 1'b0;
            e_raddr = e_act ? u_raddr[m_idx] : 5'd0;
            e_wen   = e_act ? (u_wen[m_idx] && !bus.in_flush) : 1'b0;
            e_waddr = e_act ? u_waddr[m_idx] : 5'd0;
            e_wdata = e_act ? u_wdata[m_idx] : 32'd0;
            n_checks++; if (bus.out_inst_ready !== e_rdy) begin n_err++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, bus.out_inst_ready, e_rdy); end
            n_checks++; if (bus.out_unit_en !== e_en) begin n_err++; $display("FAIL rnd_en i=%0d got=%b exp=%b", i, bus.out_unit_en, e_en); end
            n_checks++; if (bus.out_cycle_cnt !== e_cnt) begin n_err++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, bus.out_cycle_cnt, e_cnt); end
            n_checks++; if (bus.out_retire !== e_ret) begin n_err++; $display("FAIL rnd_retire i=%0d got=%b exp=%b", i, bus.out_retire, e_ret); end
            n_checks++; if (bus.out_err !== m_err) begin n_err++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, bus.out_err, m_err); end
            n_checks++; if (bus.out_rf_ren_1 !== e_ren || bus.out_rf_raddr_1 !== e_raddr) begin n_err++; $display("FAIL rnd_rd i=%0d got %b/%0d exp %b/%0d", i, bus.out_rf_ren_1, bus.out_rf_raddr_1, e_ren, e_raddr); end
            n_checks++; if (bus.out_rf_wen !== e_wen || bus.out_rf_waddr !== e_waddr || bus.out_rf_wdata !== e_wdata) begin n_err++; $display("FAIL rnd_wr i=%0d got %b/%0d/%h exp %b/%0d/%h", i, bus.out_rf_wen, bus.out_rf_waddr, bus.out_rf_wdata, e_wen, e_waddr, e_wdata); end
            tick();
        end
        bus.in_inst_valid = 1'b0;
        bus.in_flush      = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        m_phase  = 0;
        m_idx    = 0;
        m_err    = 1'b0;
        in_rst   = 1'b0;
        for (int k = 0; k < N; k++) begin
            u_ren[k] = 1'b0; u_raddr[k] = 5'd0; u_wen[k] = 1'b0; u_waddr[k] = 5'd0; u_wdata[k] = 32'd0;
        end
        bus.in_inst_valid = 1'b0;
        bus.in_unit_sel   = 4'b0;
        bus.in_flush      = 1'b0;
        apply_units();
        bus2.in_inst_valid   = 1'b0;
        bus2.in_unit_sel     = 4'b0;
        bus2.in_flush        = 1'b0;
        bus2.in_unit_ren_1   = '0;
        bus2.in_unit_raddr_1 = '0;
        bus2.in_unit_wen     = '0;
        bus2.in_unit_waddr   = '0;
        bus2.in_unit_wdata   = '0;

        test_reset();
        test_single();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_async_reset();
        test_last2();
        test_random();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
